pulse_gen_8ch: RTL
==================

Name: pulse_gen_8ch

Overview:
Multi-channel pulse/PWM generator on the output side of the frequency board. It is the transmit counterpart of the 32-channel input debounce filter. Each channel emits periodic pulses with programmable period, high time and burst count, from the 20 MHz domain. It drives external outputs and serves as loopback stimulus for the input filter and frequency-measurement path.

Parameters:
CH_NUM, 8, number of independent channels (1..32)
CNT_W, 22, width of period/high counters (4,000,000 cycles = 200 ms at 20 MHz fits)
BURST_W, 16, width of burst counter

Ports:
clk_20m  in  1  20 MHz clock
rst_n  in  1  asynchronous active-low reset
cfg_wr  in  1  config write strobe, one cycle
cfg_ch  in  $clog2(CH_NUM)  target channel of write
cfg_period  in  CNT_W  period P in cycles
cfg_high  in  CNT_W  high time H in cycles
cfg_burst  in  BURST_W  period count N; 0 = continuous
ch_start  in  CH_NUM  per-channel start pulse
ch_stop  in  CH_NUM  per-channel stop pulse
pulse_out  out  CH_NUM  registered pulse outputs
ch_busy  out  CH_NUM  channel running
ch_done  out  CH_NUM  one-cycle burst-complete pulse

Behaviour:
- Interface reset: rst_n asynchronous, active-low; clock clk_20m.
- Reset values: pulse_out=0, ch_busy=0, ch_done=0, all channels IDLE.
- Reset shadow config per channel: P=2, H=1, N=0.
- Reset mid-burst aborts immediately; no done is generated.
- cfg_wr updates only the channel's shadow registers, in the same cycle it is asserted.
- cfg_ch >= CH_NUM: the write is ignored.
- Effective config, normalised on load:
  - P<2 is treated as 2.
  - H>=P is clamped to P-1.
  - H=0 gives a constant-low output, but periods are still counted.
- Per-channel FSM states: IDLE, HIGH, LOW.
- IDLE + start (cycle t):
  - Load active config from shadow. A cfg_wr to the same channel in cycle t is written through, so the new values are used.
  - Go to HIGH, or to LOW if H=0.
  - pulse_out and ch_busy go to 1 at t+1.
- HIGH: pulse_out=1 for exactly H cycles, then LOW.
- LOW: pulse_out=0 for exactly P-H cycles. At the period boundary:
  - Increment the period count.
  - If N!=0 and count==N: go to IDLE, assert ch_done for one cycle, drop ch_busy in that same cycle.
  - Otherwise reload active config from shadow (continuous reconfiguration) and go to HIGH.
- Start while busy: ignored.
- Stop: next cycle pulse_out=0, ch_busy=0, state IDLE, no ch_done.
- Start and stop in the same cycle: stop wins.
- Stop while IDLE: no effect.
- Counters compare with ==; they never wrap because they reset at every phase change.
- Channels are fully independent. Simultaneous writes and starts on different channels are all honoured.

Optional Feature:
- Macro: PULSE_GEN_GUARD_EN.
- When defined:
  - Adds input port guard_cfg [15:0], quasi-static, sampled at every config load.
  - Effective H and P-H are each extended to at least guard_cfg+2 cycles, so P grows accordingly. This guarantees every emitted edge survives a downstream debounce filter programmed with the same value.
  - H=0 stays constant-low, and its low phase is extended instead.
- When undefined: the port is absent and there is no minimum-width adjustment.

Decomposition:
- Package pulse_gen_pkg holds:
  - State enum (IDLE/HIGH/LOW)
  - CNT_W and BURST_W defaults
  - Reset constants (P=2, H=1, N=0)
  - Config normalisation function (clamp rules, guard extension)
- Sub-module pulse_gen_ch: one channel with its shadow registers, FSM, counters and registered outputs.
- Top pulse_gen_8ch: decodes cfg_ch into per-channel write enables and instantiates CH_NUM copies via generate.

Test Plan:
- Write ch0 P=5,H=2,N=3; start at cycle 10 -> pulse_out[0] high at 11-12, 16-17, 21-22 and low elsewhere; busy 11-25; done=1 only at 26; busy=0 at 26.
- Ch1 P=4,H=1,N=0, start; stop pulsed after 7 periods -> output 1,0,0,0 repeating; one cycle after stop: out=0, busy=0, no done.
- Edge clamps: P=1,H=5 -> behaves as P=2,H=1 (toggles 1,0); H=0,P=3,N=2 -> out stays 0, done at start+7.
- Ch2 continuous P=6,H=3; cfg_wr P=4,H=2 mid-HIGH -> current period finishes as 3/3, next period is 2/2, with no glitch.
- Same-cycle events: start+stop on ch3 -> stays IDLE; start on ch4 while busy -> ignored; cfg_wr to ch5 with start in the same cycle -> new config used; rst_n low mid-burst -> all outputs 0 asynchronously.
- PULSE_GEN_GUARD_EN, guard_cfg=3, P=4,H=1 -> effective H=5, low=5, P=10; loop pulse_out into the input debounce filter with filter_cfg=3 -> every pulse is reproduced.

Source files
------------

// File: rtl/pulse_gen_8ch_pkg.sv
// pulse_gen_pkg: shared state type, size defaults, reset config and the
// config normalisation used by every pulse_gen_8ch channel.
// Optional feature macro: PULSE_GEN_GUARD_EN (minimum phase width guard).
package pulse_gen_pkg;

    localparam int CNT_W_DEF   = 22;
    localparam int BURST_W_DEF = 16;
    localparam int NORM_W      = 32;

    // Shadow config after reset: a 1-high/1-low toggle, continuous.
    localparam int RST_PERIOD  = 2;
    localparam int RST_HIGH    = 1;
    localparam int RST_BURST   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pg_state_t;

    // Effective phase lengths: hi cycles high, lo cycles low.
    typedef struct packed {
        logic [NORM_W-1:0] hi;
        logic [NORM_W-1:0] lo;
    } pg_norm_t;

    // P<2 -> 2, H>=P -> P-1; optional guard stretches both phases to at
    // least guard+2 cycles, except a zero high time stays zero.
    function automatic pg_norm_t pg_normalise(
        input logic [NORM_W-1:0] p,
        input logic [NORM_W-1:0] h,
        input logic [NORM_W-1:0] guard,
        input logic              guard_en
    );
        pg_norm_t          r;
        logic [NORM_W-1:0] pe;
        logic [NORM_W-1:0] he;
        logic [NORM_W-1:0] minw;
        pe   = (p < NORM_W'(2)) ? NORM_W'(2) : p;
        he   = (h >= pe) ? pe - NORM_W'(1) : h;
        r.hi = he;
        r.lo = pe - he;
        minw = guard + NORM_W'(2);
        if (guard_en) begin
            if ((r.hi != '0) && (r.hi < minw)) r.hi = minw;
            if (r.lo < minw) r.lo = minw;
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_gen_8ch_if.sv
// pulse_gen_8ch_if: config bus, start/stop controls and channel status.
interface pulse_gen_8ch_if
    import pulse_gen_pkg::*;
#(
    parameter int CH_NUM  = 8,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF,
    parameter int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
    logic               cfg_wr;
    logic [CH_W-1:0]    cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [BURST_W-1:0] cfg_burst;
    logic [CH_NUM-1:0]  ch_start;
    logic [CH_NUM-1:0]  ch_stop;
    logic [CH_NUM-1:0]  pulse_out;
    logic [CH_NUM-1:0]  ch_busy;
    logic [CH_NUM-1:0]  ch_done;

    modport master (
        output cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_burst, ch_start, ch_stop,
        input  pulse_out, ch_busy, ch_done
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_burst, ch_start, ch_stop,
        output pulse_out, ch_busy, ch_done
    );
endinterface

// File: rtl/pulse_gen_ch.sv
// pulse_gen_ch: one pulse channel - shadow config, IDLE/HIGH/LOW FSM,
// phase and period counters, registered outputs.
// Optional feature macro: PULSE_GEN_GUARD_EN adds guard_cfg.
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk_20m,
    input  logic               rst_n,
`ifdef PULSE_GEN_GUARD_EN
    input  logic [15:0]        guard_cfg,
`endif
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               pulse_out,
    output logic               busy,
    output logic               done
);

    logic [CNT_W-1:0]   sh_period, sh_high;
    logic [BURST_W-1:0] sh_burst;
    logic [CNT_W-1:0]   wt_period, wt_high;
    logic [BURST_W-1:0] wt_burst;
    logic [NORM_W-1:0]  guard_w;
    logic               guard_en;
    pg_norm_t           nrm;
    logic [CNT_W-1:0]   nrm_hi, nrm_lo;
    logic               unused_nrm_bits;

    logic [CNT_W-1:0]   act_hi, act_lo;
    logic [BURST_W-1:0] act_burst;
    pg_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] per_q, per_d, per_inc;
    logic               hi_last, lo_last, burst_end;
    logic               load, done_d, pout_d, busy_d;

`ifdef PULSE_GEN_GUARD_EN
    assign guard_w  = NORM_W'(guard_cfg);
    assign guard_en = 1'b1;
`else
    assign guard_w  = '0;
    assign guard_en = 1'b0;
`endif

    // A write in the same cycle as a load is seen by that load.
    assign wt_period = wr_en ? cfg_period : sh_period;
    assign wt_high   = wr_en ? cfg_high   : sh_high;
    assign wt_burst  = wr_en ? cfg_burst  : sh_burst;

    assign nrm    = pg_normalise(NORM_W'(wt_period), NORM_W'(wt_high), guard_w, guard_en);
    assign nrm_hi = nrm.hi[CNT_W-1:0];
    assign nrm_lo = nrm.lo[CNT_W-1:0];
    assign unused_nrm_bits = ^{nrm.hi[NORM_W-1:CNT_W], nrm.lo[NORM_W-1:CNT_W]};

    assign hi_last   = (cnt_q == act_hi - CNT_W'(1));
    assign lo_last   = (cnt_q == act_lo - CNT_W'(1));
    assign per_inc   = per_q + BURST_W'(1);
    assign burst_end = (act_burst != '0) && (per_inc == act_burst);

    // Shadow config: written by cfg_wr only, read at every load.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            sh_period <= CNT_W'(RST_PERIOD);
            sh_high   <= CNT_W'(RST_HIGH);
            sh_burst  <= BURST_W'(RST_BURST);
        end else if (wr_en) begin
            sh_period <= cfg_period;
            sh_high   <= cfg_high;
            sh_burst  <= cfg_burst;
        end
    end

    // Active config, captured at start and at every period boundary.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            act_hi    <= '0;
            act_lo    <= '0;
            act_burst <= '0;
        end else if (load) begin
            act_hi    <= nrm_hi;
            act_lo    <= nrm_lo;
            act_burst <= wt_burst;
        end
    end

    // State register with its phase and period counters.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
        end
    end

    // Next state: stop beats everything, start only counts from IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        load    = 1'b0;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        load    = 1'b1;
                        state_d = (nrm_hi == '0) ? LOW : HIGH;
                        cnt_d   = '0;
                        per_d   = '0;
                    end
                end
                HIGH: begin
                    if (hi_last) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (lo_last) begin
                        if (burst_end) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            load    = 1'b1;
                            state_d = (nrm_hi == '0) ? LOW : HIGH;
                            cnt_d   = '0;
                            per_d   = per_inc;
                        end
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs follow the state being entered, so they line up with it.
    always_comb begin
        pout_d = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    // Registered outputs.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pulse_out <= pout_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: rtl/pulse_gen_8ch.sv
// pulse_gen_8ch: CH_NUM independent pulse/PWM channels on clk_20m.
// Optional feature macro: PULSE_GEN_GUARD_EN adds the guard_cfg port.
module pulse_gen_8ch
    import pulse_gen_pkg::*;
#(
    parameter int CH_NUM  = 8,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic          clk_20m,
    input  logic          rst_n,
`ifdef PULSE_GEN_GUARD_EN
    input  logic [15:0]   guard_cfg,
`endif
    pulse_gen_8ch_if.slave bus
);

    logic [CH_NUM-1:0] wr_en;
    logic [CH_NUM-1:0] pout, busy, done;

    // Write decode; channel numbers beyond CH_NUM match nothing.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            wr_en[i] = bus.cfg_wr && (32'(bus.cfg_ch) == 32'(i));
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        pulse_gen_ch #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk_20m    (clk_20m),
            .rst_n      (rst_n),
`ifdef PULSE_GEN_GUARD_EN
            .guard_cfg  (guard_cfg),
`endif
            .wr_en      (wr_en[g]),
            .cfg_period (bus.cfg_period),
            .cfg_high   (bus.cfg_high),
            .cfg_burst  (bus.cfg_burst),
            .start      (bus.ch_start[g]),
            .stop       (bus.ch_stop[g]),
            .pulse_out  (pout[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

    assign bus.pulse_out = pout;
    assign bus.ch_busy   = busy;
    assign bus.ch_done   = done;

endmodule
